// File: rtl/detector_jogada_if.sv
// ============================================================================
// Module  : detector_jogada_if
// Brief   : Button-side and play-side signals of the play detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface detector_jogada_if #(
  parameter int N_BOTOES = 4
);
  logic                enable;
  logic [N_BOTOES-1:0] botoes;
  logic                jogada;
  logic                jogada_invalida;
  logic [N_BOTOES-1:0] jogada_valor;
  logic [1:0]          db_estado;

  modport master (
    output enable, botoes,
    input  jogada, jogada_invalida, jogada_valor, db_estado
  );

  modport slave (
    input  enable, botoes,
    output jogada, jogada_invalida, jogada_valor, db_estado
  );
endinterface

`default_nettype wire

// File: rtl/detector_jogada.sv
// ============================================================================
// Module  : detector_jogada
// Brief   : Synchronises and debounces the button lines and emits one
//           single-cycle play pulse (valid or invalid) per distinct press.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  detector_jogada_if.slave        bus
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    FILTRA = 2'd1,
    EMITE  = 2'd2,
    SOLTA  = 2'd3
  } estado_t;

  estado_t             state_q, state_d;
  logic [N_BOTOES-1:0] sync1_q, sync1_d;
  logic [N_BOTOES-1:0] sync2_q, sync2_d;
  logic [N_BOTOES-1:0] p_q, p_d;
  logic [N_BOTOES-1:0] valor_q, valor_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_BOTOES-1:0] s;
  logic                p_onehot;

  assign s = sync2_q;
  // A pattern is a valid play only when exactly one bit is set.
  assign p_onehot = (p_q != '0) && ((p_q & (p_q - 1'b1)) == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCIOSO;
      sync1_q <= '0;
      sync2_q <= '0;
      p_q     <= '0;
      valor_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      p_q     <= p_d;
      valor_q <= valor_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d = bus.botoes;
    sync2_d = sync1_q;
    state_d = state_q;
    p_d     = p_q;
    valor_d = valor_q;
    cnt_d   = cnt_q;

    case (state_q)
      OCIOSO: begin
        if (s != '0) begin
          cnt_d = '0;
          if (bus.enable) begin
            state_d = FILTRA;
            p_d     = s;
          end else begin
            state_d = SOLTA;
          end
        end
      end
      FILTRA: begin
        if (s == '0) begin
          state_d = OCIOSO;
        end else if (s != p_q) begin
          p_d   = s;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = EMITE;
          valor_d = p_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMITE: begin
        state_d = SOLTA;
        cnt_d   = '0;
      end
      SOLTA: begin
        // Any activity while waiting for release restarts the release count.
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  assign bus.jogada          = (state_q == EMITE) && p_onehot;
  assign bus.jogada_invalida = (state_q == EMITE) && !p_onehot;
  assign bus.jogada_valor    = valor_q;
  assign bus.db_estado       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// ============================================================================
// Module  : tb_detector_jogada
// Brief   : Scoreboard bench for detector_jogada with DEBOUNCE_CICLOS=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detector_jogada;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    bit         inv;
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t q[$];

  detector_jogada_if #(.N_BOTOES(4)) bus ();

  detector_jogada #(
    .N_BOTOES        (4),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input bit inv, input logic [3:0] val, input int at);
    exp_t e;
    e.inv = inv;
    e.val = val;
    e.at  = at;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] b, input int n);
    bus.botoes = b;
    wait_cycles(n);
  endtask

  // Monitor: every pulse the DUT presents is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.jogada && bus.jogada_invalida) begin
        total++;
        bad++;
        $display("FAIL both_pulses: jogada=1 jogada_invalida=1, expected at most one (cycle %0d)", cyc);
      end else if (bus.jogada || bus.jogada_invalida) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got inv=%0b valor=%b, expected no pulse (cycle %0d)",
                   bus.jogada_invalida, bus.jogada_valor, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_inv", int'(bus.jogada_invalida), int'(e.inv));
          chk("pulse_valor", int'(bus.jogada_valor), int'(e.val));
          if (e.at >= 0) chk("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    int e0;
    int r0;
    int want_st[8];
    want_st = '{0, 0, 1, 1, 1, 1, 2, 3};

    bus.enable = 1'b1;
    bus.botoes = 4'b0000;
    #1;
    chk("reset_jogada", int'(bus.jogada), 0);
    chk("reset_invalida", int'(bus.jogada_invalida), 0);
    chk("reset_valor", int'(bus.jogada_valor), 0);
    chk("reset_estado", int'(bus.db_estado), 0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(3);

    // 1: clean single press, exact latency and state walk
    bus.botoes = 4'b0100;
    e0 = cyc + 1;
    push(1'b0, 4'b0100, e0 + 6);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("t1_estado_k%0d", k), int'(bus.db_estado), want_st[k]);
    end
    wait_cycles(5);
    drive(4'b0000, 12);
    chk("t1_valor_hold", int'(bus.jogada_valor), 4'b0100);
    chk("t1_back_idle", int'(bus.db_estado), 0);

    // 2: bouncing press settles to one pulse
    push(1'b0, 4'b0010, -1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 2);
      drive(4'b0010, 2);
    end
    drive(4'b0010, 20);
    drive(4'b0000, 12);
    chk("t2_valor_hold", int'(bus.jogada_valor), 4'b0010);

    // 3: two buttons -> invalid pulse
    push(1'b1, 4'b0011, -1);
    drive(4'b0011, 20);
    drive(4'b0000, 12);
    chk("t3_valor_hold", int'(bus.jogada_valor), 4'b0011);

    // 4: short release does not re-arm, full release does
    push(1'b0, 4'b1000, -1);
    drive(4'b1000, 100);
    drive(4'b0000, 3);
    drive(4'b1000, 20);
    chk("t4_first_only", q.size(), 0);
    push(1'b0, 4'b1000, -1);
    drive(4'b0000, 12);
    drive(4'b1000, 20);
    drive(4'b0000, 12);

    // 5: press with enable low is swallowed until release and re-press
    bus.enable = 1'b0;
    drive(4'b0001, 20);
    chk("t5_solta_disabled", int'(bus.db_estado), 3);
    bus.enable = 1'b1;
    drive(4'b0001, 10);
    chk("t5_solta_enabled", int'(bus.db_estado), 3);
    chk("t5_valor_unchanged", int'(bus.jogada_valor), 4'b1000);
    push(1'b0, 4'b0001, -1);
    drive(4'b0000, 12);
    drive(4'b0001, 20);
    drive(4'b0000, 12);

    // 6: reset in the middle of filtering
    bus.botoes = 4'b0100;
    e0 = cyc + 1;
    wait_cycles(5);
    chk("t6_in_filtra", int'(bus.db_estado), 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_jogada", int'(bus.jogada), 0);
    chk("t6_rst_invalida", int'(bus.jogada_invalida), 0);
    chk("t6_rst_valor", int'(bus.jogada_valor), 0);
    chk("t6_rst_estado", int'(bus.db_estado), 0);
    wait_cycles(3);
    reset = 1'b1;
    r0 = cyc + 1;
    push(1'b0, 4'b0100, r0 + 6);
    wait_cycles(20);
    drive(4'b0000, 12);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clock);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse: got none, expected inv=%0b valor=%b", e.inv, e.val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
